fetch_unit: RTL

Parametrised instruction-fetch front end for the pipelined processor. It replaces the bare PC register and instruction-memory hookup at the head of the pipeline. It owns the program counter and issues pipelined requests to a fixed-latency instruction memory. Returned words are buffered with their PCs in a small prefetch queue, and decode takes them through a valid/ready handshake. It adds decode back-pressure, branch/jump redirect with squash of in-flight fetches, and configurable word, address and queue sizes.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/fetch_queue.sv | 75 +++++++
 rtl/fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, reset PC and the fetch entry
// layout that later decode stages also consume.
package pipeline_pkg;

    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam int unsigned DEFAULT_ADDR_W   = 32;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
        logic [DEFAULT_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous registered FIFO of fetch entries.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, wdata write one entry (caller guarantees a free slot)
//   pop         remove the head entry (ignored when empty)
//   clear       discard all entries, takes priority over push/pop
//   head        current head entry (stale when count == 0)
//   count       number of valid entries, 0..DEPTH
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  entry_t           wdata,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // Pointer increment that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Credit-based issue means a push never finds the queue full, even
    // when a pop happens in the same cycle.
    assert property (@(posedge clk) disable iff (rst)
                     (push && !clear) |-> (count < CNT_W'(DEPTH)))
        else $error("fetch_queue: push while full");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues pipelined requests to a
// one-cycle-latency instruction memory, buffers responses with their PCs and
// hands them to decode through a valid/ready handshake. A redirect flushes
// the queue, drops the in-flight response and restarts at redirect_pc.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   imem_req, imem_addr             request strobe and address (fetch PC)
//   imem_valid, imem_rdata          response strobe/word, one cycle later
//   instr_valid, instr, instr_pc    queue head towards decode
//   instr_ready                     decode accepts head
//   redirect, redirect_pc           taken branch/jump and its target
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STEP  = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic              issue;
    logic              push;
    logic              pop;
    entry_t            wdata;
    entry_t            head;

    // Credit check ignores a same-cycle pop so the response always has a slot.
    assign issue = !rst && !redirect && ((32'(count) + 32'(inflight)) < DEPTH);
    assign push  = imem_valid && inflight && !redirect;
    assign pop   = instr_valid && instr_ready && !redirect;
    assign wdata = '{pc: req_pc, instr: imem_rdata};

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // PC and in-flight request tracking; redirect overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(STEP);
                req_pc   <= fetch_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

endmodule
